adc5g_spi_responder: RTL and testbench
======================================

// Module: adc5g_spi_responder
// PURPOSE
//  Slave (responder) end of the e2V 5 Gsps ADC three-wire config link; the master is the serdes controller.
//  Deserialises 24-bit frames {addr[7:0], data[15:0]} sent MSB first and updates an internal register file.
//  Returns register contents on sdo for read frames.
//  Serves as the synthesizable ADC-config model in loopback/bring-up builds, with a host read-back port.
// PARAMETERS
//  NUM_REGS   16      registers implemented; index = addr[6:0], valid range 0..NUM_REGS-1
//  RESET_VAL  16'h0   value loaded into every register on rst_n or SPI reset
// PORTS
//  clk          in   1   system clock; sclk is oversampled, sclk high/low phases >= 4 clk each
//  rst_n        in   1   asynchronous active-low reset
//  spi_clk_i    in   1   serial clock from master (idles low)
//  spi_csn_i    in   1   frame enable (master mode pin), active low
//  spi_data_i   in   1   serial data in, sampled on sclk rising
//  spi_rst_n_i  in   1   SPI reset pin from master, active low
//  spi_sdo_o    out  1   serial read data, launched on sclk falling
//  spi_sdo_oe_o out  1   sdo drive enable
//  host_addr_i  in   7   host read-back index
//  host_data_o  out  16  reg[host_addr_i], combinational; RESET_VAL if out of range
//  wr_strobe_o  out  1   1-cycle pulse on each committed write
//  last_addr_o  out  7   index of last committed write
//  last_data_o  out  16  data of last committed write
//  frame_err_o  out  1   1-cycle pulse: short frame or out-of-range address
//  busy_o       out  1   FSM not IDLE
// BEHAVIOUR
//  - Inputs spi_clk_i, spi_csn_i, spi_data_i, spi_rst_n_i: 2-flop synchronisers, then 1 edge-detect register.
//  - Pin-to-event latency is fixed at 3 clk.
//  - rst_n low: FSM=IDLE, regs=RESET_VAL, all outputs 0 (host_data_o = RESET_VAL).
//  - Synced spi_rst_n low: regs=RESET_VAL, FSM=IDLE, sdo_oe=0, no strobe/err. Overrides a frame in progress.
//  - sclk edges while csn high: ignored.
//  - FSM states:
//    * IDLE: csn falling -> ADDR; bit_cnt=0.
//    * ADDR: shift data on sclk rising; after the 8th bit, latch addr. addr[7]=1 is write, 0 is read -> DATA.
//      For a read, shadow=reg[addr[6:0]] (RESET_VAL if out of range).
//    * DATA: write frames shift in 16 bits. Read frames drive sdo=shadow[15] on the first falling edge after
//      entering DATA, shifting left on each falling edge thereafter; sdo_oe=1 for the whole state.
//      After bit 24 (bit_cnt==23 on rising) -> DONE.
//      On write with index<NUM_REGS: reg<=data, last_*<=, and wr_strobe_o=1 in the following cycle.
//      On write with index>=NUM_REGS: no write; frame_err_o pulse instead.
//    * DONE: sdo_oe=0; extra sclk bits are ignored; csn rising -> IDLE.
//  - csn rising in ADDR or DATA (short frame): no write, frame_err_o pulse, -> IDLE.
//  - csn rising and a 24th sclk rising in the same cycle: the write commits (edge is processed before csn).
//  - bit_cnt is 5 bits and saturates in DONE; it never wraps.
// STRUCTURE
//  - Package adc5g_spi_pkg:
//    * ADC5G_ADDR_W=8, ADC5G_DATA_W=16, ADC5G_FRAME_W=24, ADC5G_WR_BIT=7
//    * state enum {IDLE,ADDR,DATA,DONE}
//  - Sub-module adc5g_spi_sync: 2-flop synchroniser plus rise/fall detect. Instantiated for sclk, csn and
//    spi_rst_n; sdi uses the synchroniser only.
//  - Register file: flops (NUM_REGS x 16).
// TESTING
//  1. Write 0x81/0x0348, sclk period 128 clk -> reg[1]=0x0348, one wr_strobe_o, last_addr_o=1, host_data_o(1)=0x0348.
//  2. After test 1, read frame 0x01+16 dummy bits -> sdo bits 8..23 = 0x0348 MSB first, sdo_oe high only in DATA.
//  3. csn high after 12 bits of 0x81/0xFFFF -> reg[1] unchanged, frame_err_o 1 pulse, no strobe. Next full frame commits.
//  4. Write 0xFF/0x1234 with NUM_REGS=16 -> no write, frame_err_o pulse. sclk toggling with csn high -> no activity.
//  5. spi_rst_n_i low 200 clk mid-frame -> all regs RESET_VAL, no strobe, FSM IDLE. A subsequent frame works.
//  6. rst_n asserted at bit 15 -> outputs reset immediately (async). After release, next frame behaves per test 1.

Source files
------------

// File: rtl/adc5g_spi_pkg.sv
// Shared widths, state encoding and index helper for the ADC5G config-link responder.
package adc5g_spi_pkg;

  localparam int ADC5G_ADDR_W  = 8;
  localparam int ADC5G_DATA_W  = 16;
  localparam int ADC5G_FRAME_W = 24;
  localparam int ADC5G_WR_BIT  = 7;
  localparam int ADC5G_IDX_W   = 7;

  // bit_cnt values of interest: last address bit, last frame bit, saturation ceiling
  localparam logic [4:0] ADC5G_ADDR_LAST  = 5'd7;
  localparam logic [4:0] ADC5G_FRAME_LAST = 5'd23;
  localparam logic [4:0] ADC5G_CNT_MAX    = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } adc5g_state_e;

  // True when a 7-bit register index addresses an implemented register.
  function automatic logic adc5g_idx_ok(input logic [ADC5G_IDX_W-1:0] idx,
                                        input logic [7:0]             num_regs);
    return ({1'b0, idx} < num_regs);
  endfunction

endpackage

// File: rtl/adc5g_spi_sync.sv
// Two-flop synchroniser for one SPI pin followed by a single edge-detect stage.
// Level and edge pulses both appear 3 clk after the pin changes.
module adc5g_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;
  logic r_fall;

  // Metastability chain, delayed copy and registered rise/fall detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_s3   <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_pin;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_level = r_s3;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/adc5g_spi_responder.sv
// Responder end of the ADC5G three-wire config link: deserialises {addr, data}
// frames MSB first, maintains a small register file and returns reads on sdo.
module adc5g_spi_responder
  import adc5g_spi_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk_i,
  input  logic        spi_csn_i,
  input  logic        spi_data_i,
  input  logic        spi_rst_n_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o,
  input  logic [6:0]  host_addr_i,
  output logic [15:0] host_data_o,
  output logic        wr_strobe_o,
  output logic [6:0]  last_addr_o,
  output logic [15:0] last_data_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

  // synchronised pin events
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_csn_lvl,  w_csn_rise,  w_csn_fall;
  logic w_srst_lvl, w_srst_rise, w_srst_fall;
  logic w_srst_hold;

  // data-in synchroniser (no edge detect needed)
  logic r_sdi_s1;
  logic r_sdi_s2;

  // FSM and datapath state
  adc5g_state_e r_state;
  logic [4:0]   r_bit_cnt;
  logic [14:0]  r_shift;
  logic [7:0]   r_addr;
  logic [15:0]  r_shadow;
  logic         r_sdo;
  logic         r_sdo_oe;
  logic         r_wr_strobe;
  logic         r_frame_err;
  logic [6:0]   r_last_addr;
  logic [15:0]  r_last_data;
  logic [15:0]  r_regs [NUM_REGS];

  // combinational helpers
  logic [6:0]   w_rd_idx;
  logic [15:0]  w_rd_val;
  logic [15:0]  w_host_data;
  logic [15:0]  w_wr_data;
  logic         w_wr_ok;

  adc5g_spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (spi_clk_i),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  adc5g_spi_sync #(.RST_VAL(1'b1)) u_sync_csn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (spi_csn_i),
    .o_level (w_csn_lvl),
    .o_rise  (w_csn_rise),
    .o_fall  (w_csn_fall)
  );

  adc5g_spi_sync #(.RST_VAL(1'b1)) u_sync_srst (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (spi_rst_n_i),
    .o_level (w_srst_lvl),
    .o_rise  (w_srst_rise),
    .o_fall  (w_srst_fall)
  );

  // SPI reset is level-sensitive; the fall pulse coincides with the level going low
  assign w_srst_hold = ~w_srst_lvl | w_srst_fall;

  // Two-flop synchroniser for serial data in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sdi_s1 <= 1'b0;
      r_sdi_s2 <= 1'b0;
    end else begin
      r_sdi_s1 <= spi_data_i;
      r_sdi_s2 <= r_sdi_s1;
    end
  end

  // Register index carried by the address byte completing on this sclk edge
  assign w_rd_idx  = {r_shift[5:0], r_sdi_s2};
  assign w_wr_data = {r_shift[14:0], r_sdi_s2};
  assign w_wr_ok   = adc5g_idx_ok(r_addr[6:0], NUM_REGS_L);

  // Read-shadow source: addressed register or RESET_VAL when out of range
  always_comb begin
    w_rd_val = RESET_VAL;
    if (adc5g_idx_ok(w_rd_idx, NUM_REGS_L)) begin
      w_rd_val = r_regs[w_rd_idx[IDX_W-1:0]];
    end else begin
      w_rd_val = RESET_VAL;
    end
  end

  // Host read-back mux, RESET_VAL when out of range
  always_comb begin
    w_host_data = RESET_VAL;
    if (adc5g_idx_ok(host_addr_i, NUM_REGS_L)) begin
      w_host_data = r_regs[host_addr_i[IDX_W-1:0]];
    end else begin
      w_host_data = RESET_VAL;
    end
  end

  // Frame FSM, register file and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 5'd0;
      r_shift     <= 15'd0;
      r_addr      <= 8'd0;
      r_shadow    <= 16'd0;
      r_sdo       <= 1'b0;
      r_sdo_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_last_addr <= 7'd0;
      r_last_data <= 16'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_srst_hold) begin
        // SPI reset aborts any frame silently
        r_state   <= IDLE;
        r_bit_cnt <= 5'd0;
        r_shadow  <= 16'd0;
        r_sdo     <= 1'b0;
        r_sdo_oe  <= 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
          r_regs[i] <= RESET_VAL;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_csn_fall && !w_csn_lvl) begin
              r_state   <= ADDR;
              r_bit_cnt <= 5'd0;
              r_shift   <= 15'd0;
            end else if (w_srst_rise) begin
              r_bit_cnt <= 5'd0;
            end
          end

          ADDR: begin
            if (w_csn_rise) begin
              r_frame_err <= 1'b1;
              r_state     <= IDLE;
              r_sdo       <= 1'b0;
              r_sdo_oe    <= 1'b0;
            end else if (w_sclk_rise) begin
              r_shift   <= {r_shift[13:0], r_sdi_s2};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == ADC5G_ADDR_LAST) begin
                r_addr  <= {r_shift[6:0], r_sdi_s2};
                r_state <= DATA;
                // addr[7] is r_shift[6] at this point; reads snapshot the register now
                if (!r_shift[6]) begin
                  r_shadow <= w_rd_val;
                  r_sdo_oe <= 1'b1;
                end
              end
            end
          end

          DATA: begin
            if (w_sclk_rise && (r_bit_cnt == ADC5G_FRAME_LAST)) begin
              // 24th bit wins over a coincident csn rise
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_sdo     <= 1'b0;
              r_sdo_oe  <= 1'b0;
              r_state   <= w_csn_rise ? IDLE : DONE;
              if (r_addr[ADC5G_WR_BIT]) begin
                if (w_wr_ok) begin
                  r_regs[r_addr[IDX_W-1:0]] <= w_wr_data;
                  r_last_addr <= r_addr[6:0];
                  r_last_data <= w_wr_data;
                  r_wr_strobe <= 1'b1;
                end else begin
                  r_frame_err <= 1'b1;
                end
              end
            end else if (w_csn_rise) begin
              r_frame_err <= 1'b1;
              r_state     <= IDLE;
              r_sdo       <= 1'b0;
              r_sdo_oe    <= 1'b0;
            end else begin
              if (w_sclk_rise) begin
                r_shift   <= {r_shift[13:0], r_sdi_s2};
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
              // read data launched on sclk falling, MSB first
              if (w_sclk_fall && !w_sclk_lvl && !r_addr[ADC5G_WR_BIT]) begin
                r_sdo    <= r_shadow[15];
                r_shadow <= {r_shadow[14:0], 1'b0};
              end
            end
          end

          DONE: begin
            if (w_csn_rise) begin
              r_state <= IDLE;
            end else if (w_sclk_rise && (r_bit_cnt != ADC5G_CNT_MAX)) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          default: begin
            r_state  <= IDLE;
            r_sdo    <= 1'b0;
            r_sdo_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_sdo_o    = r_sdo;
  assign spi_sdo_oe_o = r_sdo_oe;
  assign host_data_o  = w_host_data;
  assign wr_strobe_o  = r_wr_strobe;
  assign last_addr_o  = r_last_addr;
  assign last_data_o  = r_last_data;
  assign frame_err_o  = r_frame_err;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_adc5g_spi_responder.sv
// Directed bench for adc5g_spi_responder: table of write/short frames plus
// hand-written read, idle-sclk, SPI-reset and async-reset sequences.
module tb_adc5g_spi_responder;

  localparam int HALF = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk_i;
  logic        spi_csn_i;
  logic        spi_data_i;
  logic        spi_rst_n_i;
  logic        spi_sdo_o;
  logic        spi_sdo_oe_o;
  logic [6:0]  host_addr_i;
  logic [15:0] host_data_o;
  logic        wr_strobe_o;
  logic [6:0]  last_addr_o;
  logic [15:0] last_data_o;
  logic        frame_err_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_err = 0;
  int n_busy = 0;

  logic [23:0] cap_sdo;
  logic [23:0] cap_oe;

  typedef struct {
    logic [23:0] frame;
    int          nbits;
    int          exp_strobe;
    int          exp_err;
    logic [6:0]  chk_idx;
    logic [15:0] exp_host;
    logic [6:0]  exp_laddr;
    logic [15:0] exp_ldata;
  } vec_t;

  vec_t vecs [9];

  adc5g_spi_responder #(.NUM_REGS(16), .RESET_VAL(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_clk_i    (spi_clk_i),
    .spi_csn_i    (spi_csn_i),
    .spi_data_i   (spi_data_i),
    .spi_rst_n_i  (spi_rst_n_i),
    .spi_sdo_o    (spi_sdo_o),
    .spi_sdo_oe_o (spi_sdo_oe_o),
    .host_addr_i  (host_addr_i),
    .host_data_o  (host_data_o),
    .wr_strobe_o  (wr_strobe_o),
    .last_addr_o  (last_addr_o),
    .last_data_o  (last_data_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // running pulse/cycle counters sampled away from the active edge
  always @(negedge clk) begin
    if (wr_strobe_o) n_strobe++;
    if (frame_err_o) n_err++;
    if (busy_o)      n_busy++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin();
    cap_sdo   = 24'd0;
    cap_oe    = 24'd0;
    spi_csn_i = 1'b0;
    wait_clk(16);
  endtask

  task automatic send_bits(input logic [23:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_data_i = f[23-i];
      wait_clk(HALF);
      cap_sdo   = {cap_sdo[22:0], spi_sdo_o};
      cap_oe    = {cap_oe[22:0], spi_sdo_oe_o};
      spi_clk_i = 1'b1;
      wait_clk(HALF);
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic frame_end();
    wait_clk(16);
    spi_csn_i = 1'b1;
    wait_clk(16);
  endtask

  task automatic host_check(input string name, input logic [6:0] idx, input logic [15:0] exp);
    host_addr_i = idx;
    #1;
    check(name, {16'd0, host_data_o}, {16'd0, exp});
  endtask

  initial begin
    int s0, e0, b0;

    vecs[0] = '{24'h810348, 24, 1, 0, 7'd1,  16'h0348, 7'd1,  16'h0348};
    vecs[1] = '{24'h81FFFF, 12, 0, 1, 7'd1,  16'h0348, 7'd1,  16'h0348};
    vecs[2] = '{24'h81ABCD, 24, 1, 0, 7'd1,  16'hABCD, 7'd1,  16'hABCD};
    vecs[3] = '{24'hFF1234, 24, 0, 1, 7'd127, 16'h0000, 7'd1, 16'hABCD};
    vecs[4] = '{24'h8F5A5A, 24, 1, 0, 7'd15, 16'h5A5A, 7'd15, 16'h5A5A};
    vecs[5] = '{24'h901111, 24, 0, 1, 7'd16, 16'h0000, 7'd15, 16'h5A5A};
    vecs[6] = '{24'h80FFFF, 24, 1, 0, 7'd0,  16'hFFFF, 7'd0,  16'hFFFF};
    vecs[7] = '{24'h85C3C3, 8,  0, 1, 7'd5,  16'h0000, 7'd0,  16'hFFFF};
    vecs[8] = '{24'h000000, 0,  0, 1, 7'd1,  16'hABCD, 7'd0,  16'hFFFF};

    rst_n       = 1'b0;
    spi_clk_i   = 1'b0;
    spi_csn_i   = 1'b1;
    spi_data_i  = 1'b0;
    spi_rst_n_i = 1'b1;
    host_addr_i = 7'd1;
    wait_clk(5);

    // reset state
    host_check("rst host_data", 7'd1, 16'h0000);
    check("rst wr_strobe", {31'd0, wr_strobe_o}, 32'd0);
    check("rst frame_err", {31'd0, frame_err_o}, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst sdo", {31'd0, spi_sdo_o}, 32'd0);
    check("rst sdo_oe", {31'd0, spi_sdo_oe_o}, 32'd0);
    check("rst last_addr", {25'd0, last_addr_o}, 32'd0);
    check("rst last_data", {16'd0, last_data_o}, 32'd0);

    rst_n = 1'b1;
    wait_clk(10);

    // table of write and short frames
    for (int k = 0; k < 9; k++) begin
      s0 = n_strobe;
      e0 = n_err;
      frame_begin();
      send_bits(vecs[k].frame, vecs[k].nbits);
      frame_end();
      check($sformatf("v%0d strobes", k), 32'(n_strobe - s0), 32'(vecs[k].exp_strobe));
      check($sformatf("v%0d errs", k), 32'(n_err - e0), 32'(vecs[k].exp_err));
      host_check($sformatf("v%0d host_data", k), vecs[k].chk_idx, vecs[k].exp_host);
      check($sformatf("v%0d last_addr", k), {25'd0, last_addr_o}, {25'd0, vecs[k].exp_laddr});
      check($sformatf("v%0d last_data", k), {16'd0, last_data_o}, {16'd0, vecs[k].exp_ldata});
    end

    // read frames: data on bits 8..23, sdo_oe only during the data phase
    s0 = n_strobe;
    e0 = n_err;
    frame_begin();
    send_bits(24'h01FFFF, 24);
    frame_end();
    check("rd1 sdo data", {16'd0, cap_sdo[15:0]}, {16'd0, 16'hABCD});
    check("rd1 sdo_oe mask", {8'd0, cap_oe}, {8'd0, 24'h00FFFF});
    check("rd1 sdo_oe after", {31'd0, spi_sdo_oe_o}, 32'd0);
    check("rd1 strobes", 32'(n_strobe - s0), 32'd0);
    check("rd1 errs", 32'(n_err - e0), 32'd0);

    frame_begin();
    send_bits(24'h0F0000, 24);
    frame_end();
    check("rd15 sdo data", {16'd0, cap_sdo[15:0]}, {16'd0, 16'h5A5A});
    check("rd15 sdo_oe mask", {8'd0, cap_oe}, {8'd0, 24'h00FFFF});
    host_check("rd15 reg unchanged", 7'd15, 16'h5A5A);

    // sclk toggling with csn high is ignored
    s0 = n_strobe;
    e0 = n_err;
    b0 = n_busy;
    for (int i = 0; i < 10; i++) begin
      spi_data_i = i[0];
      wait_clk(8);
      spi_clk_i = 1'b1;
      wait_clk(8);
      spi_clk_i = 1'b0;
    end
    wait_clk(10);
    check("idle sclk strobes", 32'(n_strobe - s0), 32'd0);
    check("idle sclk errs", 32'(n_err - e0), 32'd0);
    check("idle sclk busy", 32'(n_busy - b0), 32'd0);

    // SPI reset mid-frame
    s0 = n_strobe;
    e0 = n_err;
    frame_begin();
    send_bits(24'h82BEEF, 12);
    check("srst busy before", {31'd0, busy_o}, 32'd1);
    spi_rst_n_i = 1'b0;
    wait_clk(200);
    spi_rst_n_i = 1'b1;
    wait_clk(16);
    check("srst busy after", {31'd0, busy_o}, 32'd0);
    frame_end();
    host_check("srst reg0", 7'd0, 16'h0000);
    host_check("srst reg1", 7'd1, 16'h0000);
    host_check("srst reg15", 7'd15, 16'h0000);
    check("srst strobes", 32'(n_strobe - s0), 32'd0);
    check("srst errs", 32'(n_err - e0), 32'd0);

    s0 = n_strobe;
    frame_begin();
    send_bits(24'h83C0DE, 24);
    frame_end();
    check("post srst strobes", 32'(n_strobe - s0), 32'd1);
    host_check("post srst reg3", 7'd3, 16'hC0DE);
    check("post srst last_addr", {25'd0, last_addr_o}, 32'd3);
    check("post srst last_data", {16'd0, last_data_o}, 32'h0000C0DE);

    // async rst_n at bit 15, checked before any further clock edge
    frame_begin();
    send_bits(24'h847777, 15);
    wait_clk(4);
    rst_n = 1'b0;
    #1;
    check("arst busy", {31'd0, busy_o}, 32'd0);
    check("arst wr_strobe", {31'd0, wr_strobe_o}, 32'd0);
    check("arst sdo_oe", {31'd0, spi_sdo_oe_o}, 32'd0);
    check("arst last_addr", {25'd0, last_addr_o}, 32'd0);
    check("arst last_data", {16'd0, last_data_o}, 32'd0);
    host_check("arst reg3", 7'd3, 16'h0000);
    spi_csn_i = 1'b1;
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(10);

    s0 = n_strobe;
    e0 = n_err;
    frame_begin();
    send_bits(24'h810348, 24);
    frame_end();
    check("post arst strobes", 32'(n_strobe - s0), 32'd1);
    check("post arst errs", 32'(n_err - e0), 32'd0);
    host_check("post arst reg1", 7'd1, 16'h0348);
    check("post arst last_addr", {25'd0, last_addr_o}, 32'd1);
    check("post arst last_data", {16'd0, last_data_o}, 32'h00000348);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
